pulse_decoder: RTL
==================

Name: pulse_decoder

Overview:
- Receive-side counterpart of the key pulse generator in the TM1638 front panel path.
- Takes the one-cycle pulse stream that a key produces (single pulse on press, then one pulse every N cycles while held) and reconstructs the hold level.
- Counts the pulses in a press and, on release, classifies the press as short or long.
- Sits between the per-key pulse outputs and the panel control logic.

Parameters:
- TIMEOUT_CYCLES, 16: maximum gap in clock cycles between pulses while a key is considered held. Must exceed the upstream repeat period. Legal range is 2 or more.
- COUNT_WIDTH, 8: width of the pulse counter and of o_Count.
- LONG_COUNT, 3: pulse count at or above which a completed press is flagged long. Legal range is 1 to 2^COUNT_WIDTH-1.

Ports:
- i_Clk  input  1  clock; all state changes on the negative edge.
- i_Rst  input  1  reset, synchronous, active-high.
- i_Pulse  input  1  pulse stream, one clock cycle wide per event.
- o_Level  output  1  reconstructed key-held level.
- o_Count  output  COUNT_WIDTH  pulse count of the current press, or of the last completed press.
- o_Release  output  1  one-cycle strobe marking the end of a press.
- o_Long  output  1  long-press flag; valid while o_Release=1 and held until the next press starts.

Behaviour:
- Timing:
  - All registers update on negedge i_Clk.
  - i_Rst is sampled on that edge.
  - All outputs are registered.
- Reset: state=IDLE, gap counter=0, o_Level=0, o_Count=0, o_Release=0, o_Long=0.
- States: IDLE, HELD, RELEASE.
- IDLE:
  - i_Pulse=1 -> HELD.
  - On that same edge: o_Level=1, o_Count=1, o_Long=0, gap=0.
  - Latency is one edge: o_Level is visible after the edge that samples the first pulse.
- HELD, i_Pulse=1:
  - gap=0.
  - o_Count increments, saturating at 2^COUNT_WIDTH-1. No wrap.
- HELD, i_Pulse=0:
  - gap increments.
  - When gap reaches TIMEOUT_CYCLES-1 with i_Pulse=0 -> RELEASE.
  - On that edge: o_Level=0, o_Release=1, o_Long=(o_Count >= LONG_COUNT).
  - o_Count freezes at its final value.
- RELEASE (lasts exactly one cycle):
  - o_Release returns to 0 on the next edge.
  - If i_Pulse=1 in this cycle: -> HELD as a new press (o_Level=1, o_Count=1, o_Long=0, gap=0).
  - Otherwise -> IDLE.
- Simultaneous events:
  - A pulse on the cycle where the gap would expire counts as a pulse.
  - In that case the gap resets and the press continues.
- Hold behaviour:
  - o_Count and o_Long hold their last values in IDLE until the next press begins.
  - o_Release never asserts for two consecutive cycles.
- Reset mid-press:
  - Returns to IDLE immediately with all outputs 0.
  - No o_Release is emitted for the aborted press.
- Width rules:
  - Gap counter width is $clog2(TIMEOUT_CYCLES)+1.
  - The count compare is unsigned.

Optional Feature:
- Macro: PULSE_DECODER_OVERFLOW_EN.
- When defined:
  - Adds output port o_Overflow (1 bit).
  - Set to 1 on the edge where o_Count would exceed 2^COUNT_WIDTH-1.
  - Sticky until the next press starts, or until i_Rst.
  - Reset value 0.
- When undefined: the port and its logic are absent, and saturation is silent.

Decomposition:
- Shared package pulse_decoder_pkg:
  - State enum typedef (IDLE, HELD, RELEASE) encoded in 2 bits.
  - Localparam function for the gap counter width.
- Sub-module gap_timer:
  - Contents: the gap counter with clear and increment inputs, and an expire output.
  - Instanced once. It is natural because the same timer will be reused by other panel timeout logic.

Test Plan (TIMEOUT_CYCLES=8, LONG_COUNT=3, COUNT_WIDTH=8 unless stated):
- Reset then idle, no pulses for 50 cycles -> all outputs 0 throughout; o_Release never asserts.
- Single pulse at cycle 10:
  - o_Level=1 and o_Count=1 after edge 10.
  - o_Release=1 for one cycle 7 edges later, with o_Level=0 and o_Long=0.
  - o_Count stays 1 afterwards.
- Pulses at cycles 10, 16, 22, 28 (gap 6):
  - o_Level stays 1 continuously; o_Count steps 1, 2, 3, 4.
  - Release strobe at edge 35 with o_Long=1.
- Gap boundary: pulses at 10 and 17 (pulse on the expiry cycle) -> no release between them; o_Count=2. Then no further pulses -> release at edge 24.
- Back-to-back presses: a pulse arrives on the RELEASE cycle -> o_Release=1 for one cycle, then o_Level=1 with o_Count=1 and o_Long=0 on the next edge.
- Reset and saturation:
  - Assert i_Rst mid-press at o_Count=2 -> all outputs 0, no release strobe.
  - With COUNT_WIDTH=2 and 5 pulses at gap 3 -> o_Count saturates at 3; with PULSE_DECODER_OVERFLOW_EN defined, o_Overflow=1 from the 4th pulse.

Source files
------------

// File: rtl/pulse_decoder_pkg.sv
// Shared types for the key pulse decoder: FSM state encoding and gap timer sizing.
package pulse_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    RELEASE = 2'd2
  } pd_state_t;

  function automatic int gap_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/pulse_decoder_gap_timer.sv
// Idle-gap timer: counts cycles since the last clear and flags
// the cycle on which one more increment reaches LIMIT-1.
module gap_timer
  import pulse_decoder_pkg::*;
#(
  parameter int LIMIT = 16,
  parameter int GW    = gap_width(LIMIT)
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  logic [GW-1:0] gap_q;

  always_ff @(negedge i_Clk) begin
    if (i_Rst) begin
      gap_q <= '0;
    end else if (clr) begin
      gap_q <= '0;
    end else if (inc) begin
      gap_q <= gap_q + GW'(1);
    end
  end

  // Looks one step ahead so the owner can act on the edge the gap lands on LIMIT-1.
  assign expire = inc && (gap_q == GW'(LIMIT - 2));

endmodule

// File: rtl/pulse_decoder.sv
// Rebuilds key hold level from a repeat-pulse stream and classifies presses.
// Optional o_Overflow output enabled by defining PULSE_DECODER_OVERFLOW_EN.
module pulse_decoder
  import pulse_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int COUNT_WIDTH    = 8,
  parameter int LONG_COUNT     = 3
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_Pulse,
  output logic                   o_Level,
  output logic [COUNT_WIDTH-1:0] o_Count,
  output logic                   o_Release,
  output logic                   o_Long
`ifdef PULSE_DECODER_OVERFLOW_EN
  ,
  output logic                   o_Overflow
`endif
);

  pd_state_t state_q;
  logic      expire;
  logic      gap_clr;
  logic      gap_inc;

  assign gap_inc = (state_q == HELD) && !i_Pulse;
  assign gap_clr = !gap_inc;

  gap_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_gap (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .clr   (gap_clr),
    .inc   (gap_inc),
    .expire(expire)
  );

  always_ff @(negedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= IDLE;
      o_Level   <= 1'b0;
      o_Count   <= '0;
      o_Release <= 1'b0;
      o_Long    <= 1'b0;
`ifdef PULSE_DECODER_OVERFLOW_EN
      o_Overflow <= 1'b0;
`endif
    end else begin
      o_Release <= 1'b0;
      unique case (state_q)
        IDLE, RELEASE: begin
          if (i_Pulse) begin
            state_q <= HELD;
            o_Level <= 1'b1;
            o_Count <= COUNT_WIDTH'(1);
            o_Long  <= 1'b0;
`ifdef PULSE_DECODER_OVERFLOW_EN
            o_Overflow <= 1'b0;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        HELD: begin
          // A pulse on the expiry cycle wins and keeps the press alive.
          if (i_Pulse) begin
            if (o_Count != '1) begin
              o_Count <= o_Count + COUNT_WIDTH'(1);
            end
`ifdef PULSE_DECODER_OVERFLOW_EN
            else begin
              o_Overflow <= 1'b1;
            end
`endif
          end else if (expire) begin
            state_q   <= RELEASE;
            o_Level   <= 1'b0;
            o_Release <= 1'b1;
            o_Long    <= (o_Count >= COUNT_WIDTH'(LONG_COUNT));
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
